store_byte_serializer: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 30 +++
 rtl/byte_lane_sel.sv | 25 ++
 rtl/store_byte_serializer.sv | 80 ++++++++
 tb/tb_store_byte_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared memory-side types for the multicycle MIPS store path: store sizes,
// serializer FSM states and word geometry.
package mips_mem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } store_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Index of the final beat; the reserved size behaves as a full word.
  function automatic logic [IDX_W-1:0] last_beat_idx(input store_size_e sz);
    case (sz)
      SZ_BYTE: return IDX_W'(0);
      SZ_HALF: return IDX_W'(1);
      default: return IDX_W'(BYTES_PER_WORD - 1);
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_sel.sv
// Selects the byte lane of a store word carried by the current beat.
// Defining STORE_BIG_ENDIAN_EN reverses lane order within the active N bytes.
module byte_lane_sel
  import mips_mem_pkg::*;
(
  input  logic [8*BYTES_PER_WORD-1:0] word_i,
  input  logic [IDX_W-1:0]            idx_i,
  input  logic [IDX_W-1:0]            last_idx_i,
  output logic [7:0]                  byte_o
);

`ifdef STORE_BIG_ENDIAN_EN
  localparam bit BIG_ENDIAN = 1'b1;
`else
  localparam bit BIG_ENDIAN = 1'b0;
`endif

  logic [IDX_W-1:0] w_lane;

  // Big-endian walks down from the top of the selected bytes, so the MSB
  // lands on the base address while addresses still count upwards.
  assign w_lane = BIG_ENDIAN ? (last_idx_i - idx_i) : idx_i;
  assign byte_o = word_i[{w_lane, 3'b000} +: 8];

endmodule

// File: rtl/store_byte_serializer.sv
// Serializes one SW/SH/SB store word into byte writes on an 8-bit memory port.
// Optional macro STORE_BIG_ENDIAN_EN sends the most-significant byte first.
module store_byte_serializer
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  output logic              ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              done_o
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  store_size_e       r_size;
  logic [IDX_W-1:0]  r_idx;

  logic [IDX_W-1:0]  w_last_idx;
  logic              w_last_beat;

  assign w_last_idx  = last_beat_idx(r_size);
  assign w_last_beat = (r_idx == w_last_idx);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      // NOTE: the data latches are reset too, so the port reads 0 after reset.
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SZ_BYTE;
      r_idx   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_size  <= store_size_e'(size_i);
            r_idx   <= '0;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ready_i) begin
            if (w_last_beat) r_state <= DONE;
            else             r_idx   <= r_idx + IDX_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Address and data decode straight from the latches, so they hold their
  // last beat outside WRITE and are qualified only by mem_we_o.
  assign ready_o    = (r_state == IDLE);
  assign mem_we_o   = (r_state == WRITE);
  assign done_o     = (r_state == DONE);
  assign mem_addr_o = r_addr + ADDR_W'(r_idx);

  byte_lane_sel u_lane_sel (
    .word_i     (r_wdata),
    .idx_i      (r_idx),
    .last_idx_i (w_last_idx),
    .byte_o     (mem_wdata_o)
  );

endmodule

// File: tb/tb_store_byte_serializer.sv
// Bench for store_byte_serializer: a beat scoreboard plus cycle-exact handshake
// checks. Expected byte order follows STORE_BIG_ENDIAN_EN when defined.
module tb_store_byte_serializer;

`ifdef STORE_BIG_ENDIAN_EN
  localparam bit BIG = 1'b1;
`else
  localparam bit BIG = 1'b0;
`endif

  logic        clk_i       = 1'b0;
  logic        rst_n_i     = 1'b0;
  logic        start_i     = 1'b0;
  logic [7:0]  addr_i      = '0;
  logic [31:0] wdata_i     = '0;
  logic [1:0]  size_i      = '0;
  logic        mem_ready_i = 1'b1;
  logic        ready_o;
  logic        mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        done_o;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests    = 0;
  int    n_fail     = 0;
  int    n_done     = 0;
  int    n_done_exp = 0;

  store_byte_serializer #(.ADDR_W(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .size_i      (size_i),
    .ready_o     (ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int n_beats(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input logic [1:0] sz, input int k);
    int lane;
    lane = BIG ? (n_beats(sz) - 1 - k) : k;
    return w[8*lane +: 8];
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: every accepted beat must match the next expected one.
  always @(negedge clk_i) begin : sb_mon
    beat_t e;
    if (rst_n_i && mem_we_o && mem_ready_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra_beat: got addr %h data %h, expected no beat", mem_addr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr_o, mem_wdata_o} !== e) begin
          n_fail++;
          $display("FAIL sb_beat: got addr %h data %h, expected addr %h data %h",
                   mem_addr_o, mem_wdata_o, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk_i) if (done_o === 1'b1) n_done++;

  task automatic push_beats(input logic [7:0] a, input logic [31:0] d, input logic [1:0] sz);
    for (int k = 0; k < n_beats(sz); k++) exp_q.push_back({a + 8'(k), exp_byte(d, sz, k)});
  endtask

  // Full store with mem_ready_i high; poke drives stray start_i during WRITE.
  task automatic run_store(input logic [7:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input bit poke, input string tag);
    int n;
    logic [7:0] ea;
    n = n_beats(sz);
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_idle: got %b, expected 1", tag, ready_o);
    end
    start_i = 1'b1; addr_i = a; wdata_i = d; size_i = sz;
    push_beats(a, d, sz);
    tick;
    for (int k = 0; k < n; k++) begin
      if (poke && k < n - 1) begin
        start_i = 1'b1; addr_i = a + 8'h40; wdata_i = ~d; size_i = 2'd0;
      end else begin
        start_i = 1'b0;
      end
      ea = a + 8'(k);
      n_tests++;
      if ({ready_o, mem_we_o, done_o, mem_addr_o, mem_wdata_o} !==
          {1'b0, 1'b1, 1'b0, ea, exp_byte(d, sz, k)}) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got rdy/we/done %b%b%b addr %h data %h, expected 010 addr %h data %h",
                 tag, k, ready_o, mem_we_o, done_o, mem_addr_o, mem_wdata_o, ea, exp_byte(d, sz, k));
      end
      tick;
    end
    start_i = 1'b0;
    n_tests++;
    if ({ready_o, mem_we_o, done_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got rdy/we/done %b%b%b, expected 001", tag, ready_o, mem_we_o, done_o);
    end
    n_done_exp++;
    tick;
    n_tests++;
    if ({ready_o, mem_we_o, done_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_ready_back: got rdy/we/done %b%b%b, expected 100", tag, ready_o, mem_we_o, done_o);
    end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0; start_i = 1'b0; mem_ready_i = 1'b1;
    #12;
    n_tests++;
    if ({ready_o, mem_we_o, mem_addr_o, mem_wdata_o, done_o} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy %b we %b addr %h data %h done %b, expected 1 0 00 00 0",
               ready_o, mem_we_o, mem_addr_o, mem_wdata_o, done_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick;
    n_tests++;
    if ({ready_o, mem_we_o, done_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got rdy/we/done %b%b%b, expected 100", ready_o, mem_we_o, done_o);
    end
  endtask

  task automatic test_word;
    run_store(8'h10, 32'hAABBCCDD, 2'd2, 1'b0, "word");
  endtask

  task automatic test_byte_half;
    run_store(8'h20, 32'h12345678, 2'd0, 1'b0, "byte");
    run_store(8'h20, 32'h12345678, 2'd1, 1'b0, "half");
    run_store(8'h40, 32'h0BADBEEF, 2'd3, 1'b0, "rsvd");
  endtask

  task automatic test_backpressure;
    int  bidx[7] = '{0, 1, 1, 1, 1, 2, 3};
    bit  brdy[7] = '{1, 0, 0, 0, 1, 1, 1};
    logic [31:0] d;
    d = 32'hAABBCCDD;
    start_i = 1'b1; addr_i = 8'h10; wdata_i = d; size_i = 2'd2;
    push_beats(8'h10, d, 2'd2);
    tick;
    start_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      mem_ready_i = brdy[c];
      n_tests++;
      if ({mem_we_o, done_o, mem_addr_o, mem_wdata_o} !==
          {1'b1, 1'b0, 8'h10 + 8'(bidx[c]), exp_byte(d, 2'd2, bidx[c])}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got we/done %b%b addr %h data %h, expected 10 addr %h data %h",
                 c + 1, mem_we_o, done_o, mem_addr_o, mem_wdata_o,
                 8'h10 + 8'(bidx[c]), exp_byte(d, 2'd2, bidx[c]));
      end
      tick;
    end
    mem_ready_i = 1'b1;
    n_tests++;
    if ({mem_we_o, done_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_done_delayed: got we/done %b%b, expected 01", mem_we_o, done_o);
    end
    n_done_exp++;
    tick;
  endtask

  task automatic test_wrap_busy;
    run_store(8'hFE, 32'hCAFEF00D, 2'd2, 1'b1, "wrap");
    tick;
    n_tests++;
    if ({ready_o, mem_we_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL busy_no_extra: got rdy/we %b%b, expected 10", ready_o, mem_we_o);
    end
  endtask

  task automatic test_reset_abort;
    int done_snap;
    start_i = 1'b1; addr_i = 8'h30; wdata_i = 32'h11223344; size_i = 2'd2;
    push_beats(8'h30, 32'h11223344, 2'd2);
    tick;
    start_i = 1'b0;
    tick;
    tick;
    #2 rst_n_i = 1'b0;
    done_snap = n_done;
    #1;
    n_tests++;
    if ({ready_o, mem_we_o, mem_addr_o, mem_wdata_o, done_o} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_async: got rdy %b we %b addr %h data %h done %b, expected 1 0 00 00 0",
               ready_o, mem_we_o, mem_addr_o, mem_wdata_o, done_o);
    end
    n_tests++;
    if (exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL abort_beats_taken: got %0d beats pending, expected 2", exp_q.size());
    end
    @(posedge clk_i);
    @(posedge clk_i);
    exp_q.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick;
    tick;
    n_tests++;
    if (n_done != done_snap) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses, expected %0d", n_done, done_snap);
    end
    run_store(8'h50, 32'h89ABCDEF, 2'd2, 1'b0, "after_abort");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_backpressure();
    test_wrap_busy();
    test_reset_abort();
    tick;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_missing_beats: got %0d pending, expected 0", exp_q.size());
    end
    n_tests++;
    if (n_done != n_done_exp) begin
      n_fail++;
      $display("FAIL done_count: got %0d, expected %0d", n_done, n_done_exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
